hex_scan_ctrl: RTL
==================

# hex_scan_ctrl

Time-multiplexing controller that shares one combinational hex-to-7-segment decoder among `NUM_DIGITS` digit positions. It double-buffers the displayed value so updates never tear mid-frame. It rotates a digit-select strobe with a per-slot blanking interval to suppress ghosting. It sits between the lab datapath (which supplies packed 4-bit nibbles) and the board's shared segment bus and digit-enable lines.

## Interface
- `NUM_DIGITS`, 4: digit positions scanned; 2..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; ≥ 4.
- `BLANK_CYCLES`, 16: cycles at the start of each slot with all digits off; 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset; one clock; asynchronous, active-low.
- `enable`  in  1  scan enable; 0 forces IDLE.
- `load`  in  1  one-cycle strobe; captures `load_data` into the shadow buffer.
- `load_data`  in  4*`NUM_DIGITS`  packed nibbles; digit k = bits [4k+3:4k].
- `blank_mask`  in  `NUM_DIGITS`  1 = digit k stays dark during its slot; sampled live.
- `seg`  out  7  active-low segments; seg[0]=a … seg[6]=g; registered.
- `an`  out  `NUM_DIGITS`  active-low digit enables; at most one low; registered.
- `digit_idx`  out  clog2(`NUM_DIGITS`)  slot currently being scanned.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the last digit's slot.
- `pending`  out  1  shadow holds data not yet committed to the active buffer.

## Operation
- Reset values: `seg`=7'h7F, `an` all 1, `digit_idx`=0, `frame_done`=0, `pending`=0, shadow=0, active=0, slot counter=0, state IDLE.
- States:
  - IDLE: all digits off. Counter and `digit_idx` held at 0. If `pending` is set, the shadow commits to active every cycle. `enable`=1 moves to BLANK.
  - BLANK: `an` all 1. After `BLANK_CYCLES` cycles, moves to SHOW.
  - SHOW: `an[digit_idx]`=0 unless `blank_mask[digit_idx]`. `seg` = decode(active nibble `digit_idx`). At slot end (counter = `REFRESH_DIV`-1), `digit_idx` increments (wrapping `NUM_DIGITS`-1 → 0) and the state moves to BLANK.
- `enable`=0 in any state moves to IDLE on the next edge. Re-enabling always restarts at digit 0 with BLANK.
- Load and commit:
  - `load`=1 writes `load_data` to the shadow and sets `pending`.
  - At the `frame_done` cycle, if `pending` is set, active ← shadow and `pending` clears.
  - If `load` coincides with the commit, the commit takes the pre-edge shadow value, the shadow takes the new data, and `pending` stays 1.
- Decoder glyphs (active-low, g..a): 0→1000000, 1→1111001, 5→0010010, 8→0000000, A→0001000, b→0000011, F→0001110. Remaining values use the standard hex glyphs.
- Slot counter width is clog2(`REFRESH_DIV`). The counter resets to 0 at slot end.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous); any pending data is lost.

## Timing
- `seg` and `an` are registered, so they lag internal state and counter by exactly 1 cycle.
- Slot length is exactly `REFRESH_DIV` cycles, of which `REFRESH_DIV`−`BLANK_CYCLES` are lit.
- Frame length is `NUM_DIGITS`×`REFRESH_DIV` cycles.
- Load-to-display latency runs from the `load` edge to the first SHOW of the next frame: at most one frame plus `BLANK_CYCLES`+1 cycles.
- `frame_done` coincides with counter = `REFRESH_DIV`-1 and `digit_idx` = `NUM_DIGITS`-1. It never asserts in IDLE.

## Structure
- Shared package `hex_disp_pkg` holds:
  - Glyph constants `SEG_BLANK`=7'h7F and `SEG_0`…`SEG_F`.
  - State encoding IDLE=2'd0, BLANK=2'd1, SHOW=2'd2.
- One sub-module, `hex7seg_decoder`: a purely combinational 4-bit → 7-bit active-low decoder, instantiated once and fed by the active-buffer mux.

## Test plan
Parameters for all scenarios: `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Reset and idle: hold `resetn`=0, then release with `enable`=0 for 20 cycles → `seg`=7F, `an`=1111, `frame_done`=0 throughout.
- Basic scan: load 16'h8A50 while in IDLE, then `enable`=1 → per slot, 2 cycles `an`=1111 followed by 6 cycles lit:
  - slot 0: `an`=1110, `seg`=1000000
  - slot 1: `an`=1101, `seg`=0010010
  - slot 2: `an`=1011, `seg`=0001000
  - slot 3: `an`=0111, `seg`=0000000
  - `frame_done` pulses every 32 cycles.
- Tear-free update: load 16'hFFFF during slot 1 → `pending`=1 and slots 1–3 still show 0x8A50. The next frame shows F (0001110) on all digits, and `pending` clears at the `frame_done` cycle.
- Load collides with commit: pending 16'h1111, then load 16'h2222 in the `frame_done` cycle → next frame shows 1111001 on every digit and `pending` stays 1. The following frame shows 2.
- Blank mask and enable drop: `blank_mask`=0010 → slot 1 stays `an`=1111. Deassert `enable` in slot 2 → `an`=1111 one cycle later and `digit_idx`=0. Re-enable → 2 blank cycles, then digit 0 lit.
- Async reset mid-SHOW: drop `resetn` at an arbitrary cycle → `seg`=7F and `an`=1111 without waiting for a clock edge. After release with `enable`=1, the display shows 0 on all digits.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display scanner.
//   - Active-low 7-segment glyph constants, bit order {g,f,e,d,c,b,a}.
//   - Scan FSM state encoding.
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit value to display
//   seg    : segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display scanner sharing one 7-segment decoder.
//   clock, resetn : system clock, asynchronous active-low reset
//   enable        : scan enable; low forces IDLE (all digits dark)
//   load          : one-cycle strobe capturing load_data into the shadow buffer
//   load_data     : packed nibbles, digit k = bits [4k+3:4k]
//   blank_mask    : 1 keeps digit k dark during its slot (sampled live)
//   seg           : registered active-low segments
//   an            : registered active-low digit enables, at most one low
//   digit_idx     : slot currently being scanned
//   frame_done    : pulse on the last cycle of the last digit's slot
//   pending       : shadow holds data not yet committed to the active buffer
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done,
  output logic                          pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLNK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t               state_q,   state_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q,  shadow_d;
  logic [4*NUM_DIGITS-1:0]   active_q,  active_d;
  logic                      pending_q, pending_d;
  logic [6:0]                seg_q,     seg_d;
  logic [NUM_DIGITS-1:0]     an_q,      an_d;

  logic [3:0] cur_nibble;
  logic       cur_masked;
  logic [6:0] dec_seg;
  logic       frame_end;
  logic       commit;

  // Select the active nibble and mask bit of the slot being scanned.
  always_comb begin
    cur_nibble = 4'h0;
    cur_masked = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nibble = active_q[4*k +: 4];
        cur_masked = blank_mask[k];
      end
    end
  end

  hex7seg_decoder u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  assign frame_end = (state_q == SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // In IDLE nothing is on screen, so a pending update may commit at once;
  // while scanning it waits for the frame boundary to avoid tearing.
  assign commit = pending_q && ((state_q == IDLE) || frame_end);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    seg_d     = SEG_BLANK;
    an_d      = '1;

    // Commit reads the pre-edge shadow, so a coincident load survives as
    // the next pending update.
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLNK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Gating with enable darkens the display on the same edge the FSM
    // drops to IDLE.
    if (enable && (state_q == SHOW)) begin
      seg_d = dec_seg;
      if (!cur_masked) an_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_end;
  assign pending    = pending_q;

endmodule
